ahbl_to_apb: RTL

AHBL_TO_APB -- requirements
Module: ahbl_to_apb

---
 rtl/ahbl_to_apb_pkg.sv | 19 +
 rtl/ahbl_to_apb.sv | 104 ++++++++++
 2 files changed

// File: rtl/ahbl_to_apb_pkg.sv
// Shared bus-fabric definitions: AHB-lite transfer types and response codes.
package ahbl_to_apb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are ignored.
    function automatic logic htrans_is_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahbl_to_apb.sv
// AHB-lite slave to APB master bridge: one outstanding transfer, single FSM,
// all bus-facing handshake outputs decoded from state.
module ahbl_to_apb
    import ahbl_to_apb_pkg::*;
#(
    parameter int W_HADDR = 32,
    parameter int W_PADDR = 16,
    parameter int W_DATA  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               src_hready,
    output logic               src_hready_resp,
    output logic               src_hresp,
    output logic               src_hexokay,
    input  logic [W_HADDR-1:0] src_haddr,
    input  logic               src_hwrite,
    input  logic [1:0]         src_htrans,
    input  logic [W_DATA-1:0]  src_hwdata,
    output logic [W_DATA-1:0]  src_hrdata,
    output logic [W_PADDR-1:0] dst_paddr,
    output logic               dst_psel,
    output logic               dst_penable,
    output logic               dst_pwrite,
    output logic [W_DATA-1:0]  dst_pwdata,
    input  logic [W_DATA-1:0]  dst_prdata,
    input  logic               dst_pready,
    input  logic               dst_pslverr
);

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        SETUP,
        ACCESS,
        ERR0,
        ERR1
    } state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   access_done;
    logic   unused_haddr;

    // Upper address bits select the bridge at the fabric level and are not forwarded.
    assign unused_haddr = ^src_haddr;

    assign accept      = ((state == IDLE) || (state == ERR1)) && src_hready
                         && htrans_is_active(src_htrans);
    assign access_done = (state == ACCESS) && dst_pready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ERR1: begin
                if (accept) begin
                    state_nxt = src_hwrite ? WR_DATA : SETUP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WR_DATA: state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS: begin
                if (dst_pready) begin
                    state_nxt = dst_pslverr ? ERR0 : IDLE;
                end
            end
            ERR0:    state_nxt = ERR1;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dst_paddr  <= '0;
            dst_pwrite <= 1'b0;
            dst_pwdata <= '0;
            src_hrdata <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                dst_paddr  <= src_haddr[W_PADDR-1:0];
                dst_pwrite <= src_hwrite;
            end
            // Write data arrives one cycle after the address phase.
            if (state == WR_DATA) begin
                dst_pwdata <= src_hwdata;
            end
            if (access_done && !dst_pwrite) begin
                src_hrdata <= dst_prdata;
            end
        end
    end

    // Decoded from state only, so no combinational path from htrans or pready.
    assign dst_psel        = (state == SETUP) || (state == ACCESS);
    assign dst_penable     = (state == ACCESS);
    assign src_hready_resp = (state == IDLE) || (state == ERR1);
    assign src_hresp       = ((state == ERR0) || (state == ERR1)) ? HRESP_ERROR : HRESP_OKAY;
    assign src_hexokay     = 1'b0;

endmodule
